// File: rtl/step_dir_generator_pkg.sv
// rtl/step_dir_generator_pkg.sv - shared stepper state and direction encodings
package step_dir_generator_pkg;

    // Move sequencing states, shared with the phase sequencer side
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } step_state_e;

    // Direction level: forward counts up, reverse counts down
    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/step_dir_generator_tick_timer.sv
// rtl/step_dir_generator_tick_timer.sv - loadable down-counter with one-cycle expire
module step_tick_timer #(
    parameter int INTERVAL_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [INTERVAL_W-1:0] load_val_i,
    output logic                  expire_o
);

    logic [INTERVAL_W-1:0] count_q;
    logic                  armed_q;

    // A load of N makes expire_o high in the N-th cycle after the load edge,
    // so the owner changes state exactly N edges after it loaded.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            armed_q <= 1'b0;
        end else if (load_i) begin
            count_q <= load_val_i - INTERVAL_W'(1);
            armed_q <= 1'b1;
        end else if (armed_q) begin
            if (count_q == '0) begin
                armed_q <= 1'b0;
            end else begin
                count_q <= count_q - INTERVAL_W'(1);
            end
        end
    end

    assign expire_o = armed_q && (count_q == '0);

endmodule

// File: rtl/step_dir_generator.sv
// rtl/step_dir_generator.sv - timed step/dir initiator with position tracking
module step_dir_generator
    import step_dir_generator_pkg::*;
#(
    parameter int MOVE_W          = 32,
    parameter int INTERVAL_W      = 32,
    parameter int PULSE_TICKS     = 8,
    parameter int DIR_SETUP_TICKS = 4,
    parameter int POS_W           = 32
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_dir,
    input  logic [MOVE_W-1:0]     cmd_steps,
    input  logic [INTERVAL_W-1:0] cmd_interval,
    input  logic                  abort,
    output logic                  step,
    output logic                  dir,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [MOVE_W-1:0]     steps_remaining,
    output logic [POS_W-1:0]      position
);

    localparam logic [INTERVAL_W-1:0] PULSE_C     = INTERVAL_W'(PULSE_TICKS);
    localparam logic [INTERVAL_W-1:0] MIN_PERIOD  = INTERVAL_W'(PULSE_TICKS + 1);
    localparam logic [INTERVAL_W-1:0] SETUP_C     = INTERVAL_W'(DIR_SETUP_TICKS);

    step_state_e           state_q;
    logic                  step_q;
    logic                  dir_q;
    logic                  done_q;
    logic                  aborted_q;
    logic                  abort_pend_q;
    logic                  noop_pend_q;
    logic [MOVE_W-1:0]     steps_rem_q;
    logic [POS_W-1:0]      pos_q;
    logic [INTERVAL_W-1:0] low_q;

    logic [INTERVAL_W-1:0] period_d;
    logic [INTERVAL_W-1:0] low_d;
    logic                  tmr_load_d;
    logic [INTERVAL_W-1:0] tmr_val_d;
    logic                  tmr_expire;
    logic [POS_W-1:0]      pos_step_d;

    step_tick_timer #(
        .INTERVAL_W (INTERVAL_W)
    ) u_timer (
        .clk_i      (CLK),
        .rst_i      (reset),
        .load_i     (tmr_load_d),
        .load_val_i (tmr_val_d),
        .expire_o   (tmr_expire)
    );

    // Clamp the period so every pulse has at least one low cycle, and derive the low time
    always_comb begin
        period_d   = (cmd_interval > MIN_PERIOD) ? cmd_interval : MIN_PERIOD;
        low_d      = period_d - PULSE_C;
        pos_step_d = (dir_q == DIR_REV) ? (pos_q - POS_W'(1)) : (pos_q + POS_W'(1));
    end

    // Timer reload requests, issued on the same edge as the state change they time
    always_comb begin
        tmr_load_d = 1'b0;
        tmr_val_d  = PULSE_C;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && (cmd_steps != '0)) begin
                    tmr_load_d = 1'b1;
                    tmr_val_d  = SETUP_C;
                end
            end
            ST_SETUP: begin
                if (tmr_expire && !abort) begin
                    tmr_load_d = 1'b1;
                    tmr_val_d  = PULSE_C;
                end
            end
            ST_HIGH: begin
                if (tmr_expire && !(abort || abort_pend_q)) begin
                    tmr_load_d = 1'b1;
                    tmr_val_d  = low_q;
                end
            end
            ST_LOW: begin
                if (tmr_expire && (steps_rem_q != '0) && !abort) begin
                    tmr_load_d = 1'b1;
                    tmr_val_d  = PULSE_C;
                end
            end
            default: begin
                tmr_load_d = 1'b0;
            end
        endcase
    end

    // Move sequencer: owns state and every registered output
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            step_q       <= 1'b0;
            dir_q        <= DIR_FWD;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            noop_pend_q  <= 1'b0;
            steps_rem_q  <= '0;
            pos_q        <= '0;
            low_q        <= '0;
        end else begin
            // A zero-step move reports done one cycle after it was accepted
            done_q      <= noop_pend_q;
            aborted_q   <= 1'b0;
            noop_pend_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_steps == '0) begin
                            noop_pend_q <= 1'b1;
                        end else begin
                            dir_q        <= cmd_dir;
                            steps_rem_q  <= cmd_steps;
                            low_q        <= low_d;
                            abort_pend_q <= 1'b0;
                            state_q      <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    if (abort) begin
                        state_q   <= ST_IDLE;
                        done_q    <= 1'b1;
                        aborted_q <= 1'b1;
                    end else if (tmr_expire) begin
                        step_q      <= 1'b1;
                        pos_q       <= pos_step_d;
                        steps_rem_q <= steps_rem_q - MOVE_W'(1);
                        state_q     <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    // An abort here is remembered so the pulse is never cut short
                    if (abort) begin
                        abort_pend_q <= 1'b1;
                    end
                    if (tmr_expire) begin
                        step_q <= 1'b0;
                        if (abort || abort_pend_q) begin
                            state_q   <= ST_IDLE;
                            done_q    <= 1'b1;
                            aborted_q <= 1'b1;
                        end else begin
                            state_q <= ST_LOW;
                        end
                    end
                end
                ST_LOW: begin
                    // Normal completion wins over an abort on the final low cycle
                    if (tmr_expire && (steps_rem_q == '0)) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end else if (abort) begin
                        state_q   <= ST_IDLE;
                        done_q    <= 1'b1;
                        aborted_q <= 1'b1;
                    end else if (tmr_expire) begin
                        step_q      <= 1'b1;
                        pos_q       <= pos_step_d;
                        steps_rem_q <= steps_rem_q - MOVE_W'(1);
                        state_q     <= ST_HIGH;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    step_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready       = (state_q == ST_IDLE);
    assign busy            = (state_q != ST_IDLE);
    assign step            = step_q;
    assign dir             = dir_q;
    assign done            = done_q;
    assign aborted         = aborted_q;
    assign steps_remaining = steps_rem_q;
    assign position        = pos_q;

endmodule

// File: tb/tb_step_dir_generator.sv
// tb/tb_step_dir_generator.sv - scoreboard bench for step_dir_generator
module tb_step_dir_generator;

    localparam int PULSE = 8;
    localparam int SETUP = 4;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_dir = 1'b0;
    logic [31:0] cmd_steps = '0;
    logic [31:0] cmd_interval = '0;
    logic        abort = 1'b0;
    logic        step;
    logic        dir;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [31:0] steps_remaining;
    logic [31:0] position;

    step_dir_generator #(
        .MOVE_W          (32),
        .INTERVAL_W      (32),
        .PULSE_TICKS     (PULSE),
        .DIR_SETUP_TICKS (SETUP),
        .POS_W           (32)
    ) dut (
        .CLK             (CLK),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_dir         (cmd_dir),
        .cmd_steps       (cmd_steps),
        .cmd_interval    (cmd_interval),
        .abort           (abort),
        .step            (step),
        .dir             (dir),
        .busy            (busy),
        .done            (done),
        .aborted         (aborted),
        .steps_remaining (steps_remaining),
        .position        (position)
    );

    typedef struct {
        int          cyc;
        logic [31:0] pos;
        logic [31:0] rem;
    } rise_t;

    typedef struct {
        int          cyc;
        logic        ab;
        logic [31:0] rem;
        logic [31:0] pos;
        logic        dir;
    } done_t;

    rise_t       rise_q[$];
    done_t       done_q[$];
    int          cyc = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          last_rise = 0;
    logic        step_prev = 1'b0;
    bit          skip_fall = 1'b0;
    logic [31:0] exp_pos = '0;
    logic        exp_dir = 1'b0;

    initial forever #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Monitor: pop expected rises and completions as the DUT produces them
    always @(negedge CLK) begin
        rise_t r;
        done_t d;
        if (step && !step_prev) begin
            chk("rise_expected", rise_q.size() != 0, 1'b1);
            if (rise_q.size() != 0) begin
                r = rise_q.pop_front();
                chk("rise_cycle", cyc, r.cyc);
                chk("rise_position", position, r.pos);
                chk("rise_remaining", steps_remaining, r.rem);
            end
            last_rise = cyc;
        end
        if (!step && step_prev) begin
            if (skip_fall) skip_fall = 1'b0;
            else chk("pulse_width", cyc - last_rise, PULSE);
        end
        if (done) begin
            chk("done_expected", done_q.size() != 0, 1'b1);
            if (done_q.size() != 0) begin
                d = done_q.pop_front();
                chk("done_cycle", cyc, d.cyc);
                chk("done_aborted", aborted, d.ab);
                chk("done_remaining", steps_remaining, d.rem);
                chk("done_position", position, d.pos);
                chk("done_dir", dir, d.dir);
                chk("done_cmd_ready", cmd_ready, 1'b1);
            end
        end
        step_prev = step;
    end

    task automatic run_to(input int target);
        while (cyc < target) @(negedge CLK);
    endtask

    // Present one command at the current negedge and queue what it should produce
    task automatic issue(input logic d, input int n, input int iv, input int nr,
                         output int e0, output int done_cyc);
        int    p;
        rise_t r;
        done_t dn;
        chk("cmd_ready_before_accept", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_dir = d;
        cmd_steps = n;
        cmd_interval = iv;
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
        cmd_dir = 1'b0;
        cmd_steps = '0;
        cmd_interval = '0;
        e0 = cyc;
        p = (iv > PULSE + 1) ? iv : PULSE + 1;
        if (n > 0) exp_dir = d;
        for (int k = 0; k < nr; k++) begin
            exp_pos = d ? exp_pos - 32'd1 : exp_pos + 32'd1;
            r.cyc = e0 + SETUP + k * p;
            r.pos = exp_pos;
            r.rem = n - k - 1;
            rise_q.push_back(r);
        end
        done_cyc = (n == 0) ? e0 + 1 : e0 + SETUP + n * p;
        if (nr == n) begin
            dn.cyc = done_cyc;
            dn.ab = 1'b0;
            dn.rem = '0;
            dn.pos = exp_pos;
            dn.dir = exp_dir;
            done_q.push_back(dn);
        end
        chk("dir_at_accept", dir, exp_dir);
        chk("busy_after_accept", busy, n != 0);
        chk("step_low_at_accept", step, 1'b0);
    endtask

    initial begin
        int    e0;
        int    dc;
        int    r3;
        done_t dn;

        // Reset state
        repeat (3) @(posedge CLK);
        #1 reset = 1'b0;
        @(negedge CLK);
        chk("rst_step", step, 1'b0);
        chk("rst_dir", dir, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_aborted", aborted, 1'b0);
        chk("rst_remaining", steps_remaining, 32'd0);
        chk("rst_position", position, 32'd0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);

        // 1: forward move, then junk commands while busy must be ignored
        issue(1'b0, 3, 20, 3, e0, dc);
        run_to(e0 + 1);
        chk("t1_busy", busy, 1'b1);
        chk("t1_cmd_ready_low", cmd_ready, 1'b0);
        chk("t1_remaining", steps_remaining, 32'd3);
        run_to(e0 + 10);
        cmd_valid = 1'b1;
        cmd_dir = 1'b1;
        cmd_steps = 99;
        cmd_interval = 3;
        run_to(e0 + 13);
        cmd_valid = 1'b0;
        cmd_dir = 1'b0;
        cmd_steps = '0;
        cmd_interval = '0;
        run_to(dc);

        // 2: reverse move accepted on the done cycle of move 1
        issue(1'b1, 2, 20, 2, e0, dc);
        run_to(dc + 2);
        chk("t2_position", position, 32'd1);

        // 3: short interval clamps the period to PULSE+1
        issue(1'b0, 2, 3, 2, e0, dc);
        run_to(dc + 2);
        chk("t3_position", position, 32'd3);

        // 4: zero-step move, dir request must not take effect
        issue(1'b1, 0, 50, 0, e0, dc);
        chk("t4_cmd_ready", cmd_ready, 1'b1);
        run_to(dc + 2);
        chk("t4_dir", dir, 1'b0);
        chk("t4_position", position, 32'd3);

        // 5: abort during the third pulse lets it finish, then stops
        issue(1'b0, 10, 20, 3, e0, dc);
        r3 = e0 + SETUP + 2 * 20;
        dn.cyc = r3 + PULSE;
        dn.ab = 1'b1;
        dn.rem = 32'd7;
        dn.pos = exp_pos;
        dn.dir = 1'b0;
        done_q.push_back(dn);
        run_to(r3 + 1);
        abort = 1'b1;
        @(posedge CLK);
        #1 abort = 1'b0;
        run_to(r3 + PULSE + 3);
        chk("t5_busy", busy, 1'b0);
        chk("t5_position", position, 32'd6);

        // Abort while idle is ignored
        abort = 1'b1;
        @(posedge CLK);
        #1 abort = 1'b0;
        @(negedge CLK);
        chk("idle_abort_busy", busy, 1'b0);
        chk("idle_abort_done", done, 1'b0);

        // 6: reset during a pulse, then a fresh move
        issue(1'b1, 5, 20, 2, e0, dc);
        run_to(e0 + SETUP + 20 + 3);
        chk("t6_step_high_before_reset", step, 1'b1);
        reset = 1'b1;
        skip_fall = 1'b1;
        @(posedge CLK);
        #1 reset = 1'b0;
        rise_q.delete();
        done_q.delete();
        exp_pos = '0;
        exp_dir = 1'b0;
        @(negedge CLK);
        chk("t6_step", step, 1'b0);
        chk("t6_position", position, 32'd0);
        chk("t6_cmd_ready", cmd_ready, 1'b1);
        chk("t6_busy", busy, 1'b0);
        chk("t6_done", done, 1'b0);
        run_to(cyc + 3);
        issue(1'b0, 2, 10, 2, e0, dc);
        run_to(dc + 2);
        chk("t6_new_position", position, 32'd2);

        chk("rise_queue_drained", rise_q.size(), 0);
        chk("done_queue_drained", done_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
